// File: rtl/instr_fetch_unit.sv
// Program counter and instruction fetch stage: fetches one word per instruction over
// a req/ack port, holds it for the execute window, then selects the next PC.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [1:0]  branch_type_i,
    input  logic        jump_i,
    input  logic        zero_i,
    input  logic        sign_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] retired_cnt_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_off;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic        w_cond;
    logic [31:0] w_next_pc;

    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_branch_off    = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_branch_target = w_pc_plus4 + w_branch_off;
    assign w_jump_target   = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};

    always_comb begin
        w_cond = 1'b0;
        case (branch_type_i)
            2'b00:   w_cond = zero_i;
            2'b01:   w_cond = zero_i | sign_i;
            2'b10:   w_cond = sign_i;
            default: w_cond = ~zero_i;
        endcase
    end

    // Jump outranks a simultaneous branch request.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jump_i) begin
            w_next_pc = w_jump_target;
        end else if (branch_i && w_cond) begin
            w_next_pc = w_branch_target;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_BOOT;
            r_pc      <= RESET_PC;
            r_instr   <= 32'd0;
            r_retired <= 32'd0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack_i) begin
                        r_instr <= imem_rdata_i;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!stall_i) begin
                        r_pc      <= w_next_pc;
                        r_retired <= r_retired + 32'd1;
                        r_state   <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    // Handshake flags come straight from the state register, so they can never overlap.
    assign imem_req_o    = (r_state == ST_FETCH);
    assign instr_valid_o = (r_state == ST_EXEC);
    assign imem_addr_o   = r_pc;
    assign pc_o          = r_pc;
    assign pc_plus4_o    = w_pc_plus4;
    assign instr_o       = r_instr;
    assign retired_cnt_o = r_retired;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: drives fetch/execute sequences on the falling
// edge and compares outputs against hand-computed PCs, words and counts.
module tb_instr_fetch_unit;

    logic        clk_i;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        stall_i;
    logic        branch_i;
    logic [1:0]  branch_type_i;
    logic        jump_i;
    logic        zero_i;
    logic        sign_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [31:0] retired_cnt_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .stall_i       (stall_i),
        .branch_i      (branch_i),
        .branch_type_i (branch_type_i),
        .jump_i        (jump_i),
        .zero_i        (zero_i),
        .sign_i        (sign_i),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .retired_cnt_o (retired_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Entered on a falling edge while in FETCH; leaves on the falling edge of the next FETCH.
    task automatic run_instr(input string name, input logic [31:0] word, input int waits,
                             input int stalls, input logic br, input logic [1:0] bt,
                             input logic jmp, input logic z, input logic s,
                             input logic [31:0] next_pc);
        chk1 ({name, ".req"},  imem_req_o, 1'b1);
        chk32({name, ".addr"}, imem_addr_o, exp_pc);
        chk32({name, ".pc4"},  pc_plus4_o, exp_pc + 32'd4);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk_i);
            chk32({name, ".wait_addr"},  imem_addr_o, exp_pc);
            chk1 ({name, ".wait_valid"}, instr_valid_o, 1'b0);
            chk32({name, ".wait_cnt"},   retired_cnt_o, exp_cnt);
        end
        imem_ack_i   = 1'b1;
        imem_rdata_i = word;
        @(negedge clk_i);
        imem_ack_i   = 1'b0;
        imem_rdata_i = 32'h0;
        chk1 ({name, ".valid"}, instr_valid_o, 1'b1);
        chk1 ({name, ".exreq"}, imem_req_o, 1'b0);
        chk32({name, ".instr"}, instr_o, word);
        for (int i = 0; i < stalls; i++) begin
            stall_i      = 1'b1;
            imem_ack_i   = 1'b1;
            imem_rdata_i = 32'hDEAD_BEEF;
            @(negedge clk_i);
            chk1 ({name, ".stall_valid"}, instr_valid_o, 1'b1);
            chk32({name, ".stall_pc"},    pc_o, exp_pc);
            chk32({name, ".stall_instr"}, instr_o, word);
            chk32({name, ".stall_cnt"},   retired_cnt_o, exp_cnt);
        end
        stall_i       = 1'b0;
        imem_ack_i    = 1'b0;
        imem_rdata_i  = 32'h0;
        branch_i      = br;
        branch_type_i = bt;
        jump_i        = jmp;
        zero_i        = z;
        sign_i        = s;
        @(negedge clk_i);
        exp_pc  = next_pc;
        exp_cnt = exp_cnt + 32'd1;
        branch_i = 1'b0; branch_type_i = 2'b00; jump_i = 1'b0; zero_i = 1'b0; sign_i = 1'b0;
        chk32({name, ".next_pc"}, pc_o, exp_pc);
        chk32({name, ".cnt"},     retired_cnt_o, exp_cnt);
        chk1 ({name, ".fvalid"},  instr_valid_o, 1'b0);
        $display("txn %-8s word=%h next_pc=%h retired=%0d", name, word, pc_o, retired_cnt_o);
    endtask

    initial begin
        rst_i = 1'b1; imem_ack_i = 1'b0; imem_rdata_i = 32'h0; stall_i = 1'b0;
        branch_i = 1'b0; branch_type_i = 2'b00; jump_i = 1'b0; zero_i = 1'b0; sign_i = 1'b0;
        exp_pc = 32'h0; exp_cnt = 32'h0;

        @(negedge clk_i);
        @(negedge clk_i);
        chk32("rst.pc", pc_o, 32'h0);
        chk32("rst.instr", instr_o, 32'h0);
        chk1 ("rst.valid", instr_valid_o, 1'b0);
        chk1 ("rst.req", imem_req_o, 1'b0);
        chk32("rst.cnt", retired_cnt_o, 32'h0);
        rst_i = 1'b0;
        chk1 ("boot.req", imem_req_o, 1'b0);
        @(negedge clk_i);

        // Sequential fetch, zero-wait memory.
        run_instr("seq0", 32'h0000_0020, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h04);
        run_instr("seq4", 32'h0000_0021, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h08);
        run_instr("seq8", 32'h0000_0022, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0C);
        run_instr("seqC", 32'h0000_0023, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h10);
        // beq taken backwards after 3 wait states.
        run_instr("beq_t", 32'h1000_FFFE, 3, 0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0C);
        run_instr("seqC2", 32'h0000_0024, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h10);
        run_instr("beq_nt", 32'h1000_FFFE, 0, 0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h14);
        run_instr("j10a", 32'h0800_0004, 0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h10);
        run_instr("bne_t", 32'h1400_0002, 0, 0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 32'h1C);
        run_instr("j10b", 32'h0800_0004, 0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h10);
        run_instr("blez_t", 32'h1800_0004, 0, 0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 32'h24);
        run_instr("j10c", 32'h0800_0004, 0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h10);
        run_instr("bltz_nt", 32'h0400_0004, 0, 0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 32'h14);
        run_instr("j20", 32'h0800_0008, 0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h20);
        // Jump and branch together: jump wins.
        run_instr("jbr", 32'h0800_0040, 0, 0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 32'h100);
        // Two stall cycles with stray acks during EXEC.
        run_instr("stall", 32'h0000_0025, 0, 2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h104);
        // Branch to the top of the address space, then wrap through pc+4.
        run_instr("b_top", 32'h1000_FFBD, 0, 0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
        run_instr("j_wrap", 32'h0800_0010, 0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h40);

        // Reset during a fetch wait at 0x40, then a late ack.
        chk32("rf.addr", imem_addr_o, 32'h40);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk32("rf.pc", pc_o, 32'h0);
        chk1 ("rf.req", imem_req_o, 1'b0);
        chk1 ("rf.valid", instr_valid_o, 1'b0);
        chk32("rf.instr", instr_o, 32'h0);
        chk32("rf.cnt", retired_cnt_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        imem_ack_i = 1'b1;
        imem_rdata_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        imem_rdata_i = 32'h0;
        chk32("rf.late_instr", instr_o, 32'h0);
        chk1 ("rf.late_req", imem_req_o, 1'b1);
        chk1 ("rf.late_valid", instr_valid_o, 1'b0);
        $display("txn reset    pc=%h instr=%h retired=%0d", pc_o, instr_o, retired_cnt_o);
        exp_pc = 32'h0; exp_cnt = 32'h0;
        run_instr("post_rst", 32'h0000_0026, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h04);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
